// File: rtl/str_gen.sv
// Stream traffic generator for the tbn bus: emits multi-beat packets with tlast,
// incrementing / LFSR / constant value patterns and fixed inter-beat gaps.
module str_gen #(
  parameter int unsigned   VW   = 32,
  parameter int unsigned   LW   = 16,
  parameter int unsigned   CW   = 32,
  parameter logic [VW-1:0] POLY = 32'h80200003
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [1:0]    mode,
  input  logic [VW-1:0] seed,
  input  logic [3:0]    gap,
  output logic          tvalid,
  input  logic          tready,
  output logic [VW-1:0] tvalue,
  output logic          tlast,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] beats
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] rem_q;
  logic [1:0]    mode_q;
  logic [3:0]    gap_q;
  logic [3:0]    gcnt_q;
  logic [VW-1:0] value_q;
  logic [CW-1:0] beats_q;
  logic          done_q;

  logic          xfer;
  logic          final_beat;
  logic          load;
  logic          advance;

  function automatic logic [VW-1:0] next_value(input logic [1:0] m, input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v + VW'(1);
    case (m)
      2'd1:    r = (v >> 1) ^ (v[0] ? POLY : '0);
      2'd2:    r = v;
      default: r = v + VW'(1);
    endcase
    return r;
  endfunction

  // Handshake outputs decode straight from the state so an async reset clears them at once.
  assign tvalid     = (state_q == SEND);
  assign final_beat = (rem_q == LW'(1));
  assign tlast      = tvalid & final_beat;
  assign busy       = (state_q != IDLE);
  assign xfer       = tvalid & tready;
  assign tvalue     = value_q;
  assign beats      = beats_q;
  assign done       = done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (final_beat) begin
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            state_d = (gap_q == 4'd0) ? SEND : GAP;
          end
        end
      end
      GAP: begin
        if (gcnt_q == 4'd1) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mode_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      value_q <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= xfer & final_beat;
      if (xfer) beats_q <= beats_q + CW'(1);

      if (load) begin
        rem_q   <= len;
        mode_q  <= mode;
        gap_q   <= gap;
        value_q <= seed;
      end else if (advance) begin
        rem_q   <= rem_q - LW'(1);
        value_q <= next_value(mode_q, value_q);
      end

      // The gap counter reloads on every non-final beat and counts down while idling.
      if (advance && (gap_q != 4'd0)) begin
        gcnt_q <= gap_q;
      end else if (state_q == GAP) begin
        gcnt_q <= gcnt_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_str_gen.sv
// Self-checking bench for str_gen: directed packets, a beat scoreboard fed by the
// stimulus and drained by an independent stream monitor.
module tb_str_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [3:0]  gap;
  logic        tvalid;
  logic        tready;
  logic [31:0] tvalue;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [31:0] beats;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int stall_left = 0;
  logic [31:0] stall_val = '0;
  logic [32:0] sbq[$];

  str_gen dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .seed(seed), .gap(gap),
    .tvalid(tvalid), .tready(tready), .tvalue(tvalue), .tlast(tlast),
    .busy(busy), .done(done), .beats(beats)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic last, input logic [31:0] v);
    sbq.push_back({last, v});
  endtask

  // Monitor: pops one expected beat per handshake and checks that stalled beats hold.
  initial begin : monitor
    logic [32:0] exp_beat;
    logic [32:0] held_beat;
    logic        held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) check("hold_stable", {tvalid, tlast, tvalue}, {1'b1, held_beat});
        held = 1'b0;
        if (tvalid && tready) begin
          hs_count++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got %0h expected no beat", {tlast, tvalue});
          end else begin
            exp_beat = sbq.pop_front();
            check("beat", {tlast, tvalue}, exp_beat);
          end
        end else if (tvalid) begin
          held      = 1'b1;
          held_beat = {tlast, tvalue};
        end
      end
    end
  end

  // Sink: ready except for a programmed number of stall cycles on one value.
  initial begin : sink
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && tvalid && tvalue == stall_val) begin
        tready = 1'b0;
        stall_left--;
      end else begin
        tready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done expected done within 300 cycles", name);
    end
  endtask

  // Issues one packet, scrambles the inputs mid-packet and measures the valid span.
  task automatic run_pkt(input logic [15:0] l, input logic [1:0] m, input logic [31:0] s,
                         input logic [3:0] g, output int span);
    int first;
    int last;
    int done_at;
    @(posedge clk); #1;
    start = 1'b1; len = l; mode = m; seed = s; gap = g;
    @(posedge clk); #1;
    start = 1'b0; len = 16'd3; mode = ~m; seed = 32'hDEAD_BEEF; gap = 4'd5;
    first = -1; last = -1; done_at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tvalid) begin
        if (first < 0) first = i;
        last = i;
      end
      if (done) begin
        done_at = i;
        break;
      end
    end
    if (done_at < 0) begin
      checks++;
      errors++;
      $display("FAIL pkt_timeout: got no done expected done within 300 cycles");
    end
    check("first_valid_latency", first, 0);
    check("done_after_last", done_at, last + 1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    span = last - first + 1;
  endtask

  initial begin : stim
    int span;
    rst = 1'b1; start = 1'b0; len = '0; mode = '0; seed = '0; gap = '0;
    #12;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tvalue", tvalue, 32'h0);
    check("rst_beats", beats, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: back-to-back incrementing packet
    push_beat(0, 32'h10); push_beat(0, 32'h11); push_beat(0, 32'h12); push_beat(1, 32'h13);
    run_pkt(16'd4, 2'd0, 32'h10, 4'd0, span);
    check("t1_span", span, 4);
    check("t1_beats", beats, 32'd4);

    // 2: sink stalls three cycles on the second beat
    stall_val = 32'h21; stall_left = 3;
    push_beat(0, 32'h20); push_beat(0, 32'h21); push_beat(0, 32'h22); push_beat(1, 32'h23);
    run_pkt(16'd4, 2'd0, 32'h20, 4'd0, span);
    check("t2_span", span, 7);
    check("t2_beats", beats, 32'd8);

    // 3: two idle cycles between beats
    push_beat(0, 32'h30); push_beat(0, 32'h31); push_beat(0, 32'h32); push_beat(1, 32'h33);
    run_pkt(16'd4, 2'd0, 32'h30, 4'd2, span);
    check("t3_span", span, 10);
    check("t3_beats", beats, 32'd12);

    // 4: LFSR sequence from seed 1
    push_beat(0, 32'h0000_0001); push_beat(0, 32'h8020_0003); push_beat(1, 32'hC030_0002);
    run_pkt(16'd3, 2'd1, 32'h1, 4'd0, span);
    check("t4_span", span, 3);
    check("t4_beats", beats, 32'd15);

    // constant mode with a one-cycle gap
    push_beat(0, 32'hA5); push_beat(0, 32'hA5); push_beat(1, 32'hA5);
    run_pkt(16'd3, 2'd2, 32'hA5, 4'd1, span);
    check("const_span", span, 5);
    check("const_beats", beats, 32'd18);

    // mode 3 increments; a new start lands in the done cycle of the previous packet
    push_beat(1, 32'h7);
    @(posedge clk); #1;
    start = 1'b1; len = 16'd1; mode = 2'd3; seed = 32'h7; gap = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("chain_first_done");
    push_beat(0, 32'h40); push_beat(1, 32'h41);
    start = 1'b1; len = 16'd2; mode = 2'd3; seed = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    check("chain_accepted", {busy, tvalid}, 2'b11);
    wait_done("chain_second_done");
    check("chain_beats", beats, 32'd21);
    check("sb_drained_a", sbq.size(), 0);

    // 5: reset in the middle of an 8-beat packet
    for (int i = 0; i < 8; i++) push_beat(i == 7, 32'h50 + 32'(i));
    @(posedge clk); #1;
    start = 1'b1; len = 16'd8; mode = 2'd0; seed = 32'h50; gap = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && beats != 32'd23; i++) @(negedge clk);
    check("t5_mid_value", tvalue, 32'h52);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_tvalid", tvalid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_beats", beats, 32'h0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_no_resume", {busy, tvalid}, 2'b00);

    // 6: wrap from all-ones, ignored starts while busy and with len 0
    push_beat(0, 32'hFFFF_FFFF); push_beat(1, 32'h0);
    @(posedge clk); #1;
    start = 1'b1; len = 16'd2; mode = 2'd0; seed = 32'hFFFF_FFFF; gap = 4'd0;
    @(posedge clk); #1;
    len = 16'd5; seed = 32'h123;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6_done");
    @(posedge clk); #1;
    start = 1'b1; len = 16'd0; seed = 32'h99;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t6_len0_ignored", {busy, tvalid}, 2'b00);
    check("t6_beats", beats, 32'd2);
    repeat (3) @(negedge clk);
    check("sb_drained_b", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
